rename_freelist: RTL and testbench

- Parametrised physical-register free list for the rename stage.
- Allocates up to ALLOC_WIDTH destination pregs per cycle, in order, to the renaming logic.
- Reclaims up to COMMIT_WIDTH stale pregs per cycle from retire.
- On flush, rolls back all speculative allocations to the committed point in one cycle.

---
 rtl/rename_freelist.sv | 170 +++++++++++++++++
 tb/tb_rename_freelist.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/rename_freelist.sv
//------------------------------------------------------------------------------
// Module   : rename_freelist
// Purpose  : Physical-register free list for rename with flush rollback.
// Options  : FREELIST_DUP_CHECK_EN - is_free bitmap and sticky dup_err.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rename_freelist #(
   parameter int NUM_PREG     = 64,
   parameter int NUM_AREG     = 32,
   parameter int ALLOC_WIDTH  = 2,
   parameter int COMMIT_WIDTH = 2,
   localparam int PREG_W      = $clog2(NUM_PREG),
   localparam int PTR_W       = PREG_W + 1,
   localparam int CNT_W       = $clog2(NUM_PREG + 1)
) (
   input  logic                           clk,
   input  logic                           resetn,
   input  logic                           alloc_valid,
   input  logic [ALLOC_WIDTH-1:0]         alloc_req,
   output logic                           alloc_ready,
   output logic [ALLOC_WIDTH*PREG_W-1:0]  alloc_preg,
   input  logic [COMMIT_WIDTH-1:0]        commit_valid,
   input  logic [COMMIT_WIDTH*PREG_W-1:0] commit_old_preg,
   input  logic                           flush,
   output logic [CNT_W-1:0]               free_count,
   output logic                           dup_err
);

   localparam int c_INIT_FREE = NUM_PREG - NUM_AREG;

   logic [PREG_W-1:0] r_fl [NUM_PREG];
   logic [PTR_W-1:0]  r_head;
   logic [PTR_W-1:0]  r_commitHead;
   logic [PTR_W-1:0]  r_tail;
   logic [CNT_W-1:0]  r_freeCount;

   logic [PTR_W-1:0]  w_allocOfs  [ALLOC_WIDTH];
   logic [PTR_W-1:0]  w_commitOfs [COMMIT_WIDTH];
   logic [PTR_W-1:0]  w_allocCnt;
   logic [PTR_W-1:0]  w_commitCnt;
   logic [PREG_W-1:0] w_allocId   [ALLOC_WIDTH];
   logic [PREG_W-1:0] w_relIdx    [COMMIT_WIDTH];
   logic              w_fire;
   logic [PTR_W-1:0]  w_headNext;
   logic [PTR_W-1:0]  w_commitHeadNext;
   logic [PTR_W-1:0]  w_tailNext;

   // Exclusive prefix popcounts give each valid slot its compacted offset.
   always_comb begin
      logic [PTR_W-1:0] acc;
      acc = '0;
      for (int i = 0; i < ALLOC_WIDTH; i++) begin
         w_allocOfs[i] = acc;
         acc = acc + PTR_W'(alloc_req[i]);
      end
      w_allocCnt = acc;
   end

   always_comb begin
      logic [PTR_W-1:0] acc;
      acc = '0;
      for (int j = 0; j < COMMIT_WIDTH; j++) begin
         w_commitOfs[j] = acc;
         acc = acc + PTR_W'(commit_valid[j]);
      end
      w_commitCnt = acc;
   end

   generate
      for (genvar i = 0; i < ALLOC_WIDTH; i++) begin : g_allocSlot
         logic [PTR_W-1:0] w_ptr;
         assign w_ptr        = r_head + w_allocOfs[i];
         assign w_allocId[i] = r_fl[w_ptr[PREG_W-1:0]];
         assign alloc_preg[i*PREG_W +: PREG_W] = w_allocId[i];
      end
      for (genvar j = 0; j < COMMIT_WIDTH; j++) begin : g_relSlot
         logic [PTR_W-1:0] w_ptr;
         assign w_ptr       = r_tail + w_commitOfs[j];
         assign w_relIdx[j] = w_ptr[PREG_W-1:0];
      end
   endgenerate

   assign alloc_ready      = !flush && (r_freeCount >= CNT_W'(w_allocCnt));
   assign w_fire           = alloc_valid && alloc_ready;
   assign w_commitHeadNext = r_commitHead + w_commitCnt;
   assign w_tailNext       = r_tail + w_commitCnt;
   // Flush rewinds to the committed point including this cycle's retirements.
   assign w_headNext       = flush  ? w_commitHeadNext :
                             w_fire ? r_head + w_allocCnt : r_head;
   assign free_count       = r_freeCount;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < NUM_PREG; i++)
            r_fl[i] <= (i < c_INIT_FREE) ? PREG_W'(NUM_AREG + i) : '0;
         r_head       <= '0;
         r_commitHead <= '0;
         r_tail       <= PTR_W'(c_INIT_FREE);
         r_freeCount  <= CNT_W'(c_INIT_FREE);
      end else begin
         for (int j = 0; j < COMMIT_WIDTH; j++)
            if (commit_valid[j])
               r_fl[w_relIdx[j]] <= commit_old_preg[j*PREG_W +: PREG_W];
         r_head       <= w_headNext;
         r_commitHead <= w_commitHeadNext;
         r_tail       <= w_tailNext;
         r_freeCount  <= CNT_W'(w_tailNext - w_headNext);
      end
   end

`ifdef FREELIST_DUP_CHECK_EN
   logic [NUM_PREG-1:0] r_isFree;
   logic [NUM_PREG-1:0] w_isFreeNext;
   logic                r_dupErr;
   logic                w_dup;

   always_comb begin
      logic [PTR_W-1:0]  specCnt;
      logic [PTR_W-1:0]  idx;
      logic [PREG_W-1:0] oldJ;
      w_isFreeNext = r_isFree;
      w_dup        = 1'b0;
      idx          = '0;
      oldJ         = '0;
      specCnt      = r_head - w_commitHeadNext;
      if (w_fire)
         for (int i = 0; i < ALLOC_WIDTH; i++)
            if (alloc_req[i]) w_isFreeNext[w_allocId[i]] = 1'b0;
      if (flush)
         for (int k = 0; k < NUM_PREG; k++) begin
            idx = w_commitHeadNext + PTR_W'(k);
            if (PTR_W'(k) < specCnt) w_isFreeNext[r_fl[idx[PREG_W-1:0]]] = 1'b1;
         end
      for (int j = 0; j < COMMIT_WIDTH; j++) begin
         oldJ = commit_old_preg[j*PREG_W +: PREG_W];
         if (commit_valid[j]) begin
            if (r_isFree[oldJ]) w_dup = 1'b1;
            for (int m = j + 1; m < COMMIT_WIDTH; m++)
               if (commit_valid[m] && commit_old_preg[m*PREG_W +: PREG_W] == oldJ)
                  w_dup = 1'b1;
            w_isFreeNext[oldJ] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < NUM_PREG; i++) r_isFree[i] <= (i >= NUM_AREG);
         r_dupErr <= 1'b0;
      end else begin
         r_isFree <= w_isFreeNext;
         r_dupErr <= r_dupErr | w_dup;
      end
   end

   assign dup_err = r_dupErr;
`else
   assign dup_err = 1'b0;
`endif

`ifndef SYNTHESIS
   always @(posedge clk)
      if (resetn) a_noOverflow: assert (r_freeCount <= CNT_W'(NUM_PREG));
`endif

endmodule

`default_nettype wire

// File: tb/tb_rename_freelist.sv
//------------------------------------------------------------------------------
// Module   : tb_rename_freelist
// Purpose  : Directed vector table plus multi-cycle sequences for rename_freelist.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_rename_freelist;

   localparam int PW = 6;

   logic          clk = 1'b0;
   logic          resetn;
   logic          alloc_valid;
   logic [1:0]    alloc_req;
   logic          alloc_ready;
   logic [2*PW-1:0] alloc_preg;
   logic [1:0]    commit_valid;
   logic [2*PW-1:0] commit_old_preg;
   logic          flush;
   logic [6:0]    free_count;
   logic          dup_err;

   int passed = 0;
   int total  = 0;

   rename_freelist #(
      .NUM_PREG(64), .NUM_AREG(32), .ALLOC_WIDTH(2), .COMMIT_WIDTH(2)
   ) dut (
      .clk(clk), .resetn(resetn),
      .alloc_valid(alloc_valid), .alloc_req(alloc_req),
      .alloc_ready(alloc_ready), .alloc_preg(alloc_preg),
      .commit_valid(commit_valid), .commit_old_preg(commit_old_preg),
      .flush(flush), .free_count(free_count), .dup_err(dup_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       av;
      logic [1:0] req;
      logic [1:0] cv;
      int         o0;
      int         o1;
      logic       fl;
      int         eRdy;
      int         eFree;
      logic [1:0] chk;
      int         eP0;
      int         eP1;
   } vec_t;

   vec_t vecs [9];

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   task automatic drive(input logic av, input logic [1:0] req, input logic [1:0] cv,
                        input int o0, input int o1, input logic fl);
      alloc_valid     = av;
      alloc_req       = req;
      commit_valid    = cv;
      commit_old_preg = {PW'(o1), PW'(o0)};
      flush           = fl;
   endtask

   task automatic doReset();
      resetn = 1'b0;
      drive(1'b0, 2'b00, 2'b00, 0, 0, 1'b0);
      @(negedge clk);
      @(negedge clk);
      resetn = 1'b1;
   endtask

   function automatic int p0();
      return int'(alloc_preg[PW-1:0]);
   endfunction

   function automatic int p1();
      return int'(alloc_preg[2*PW-1:PW]);
   endfunction

   initial begin
      // av req cv o0 o1 fl | rdy free chk p0 p1
      vecs[0] = '{1'b0, 2'b11, 2'b00, 0, 0, 1'b0, 1, 32, 2'b11, 32, 33};
      vecs[1] = '{1'b1, 2'b10, 2'b00, 0, 0, 1'b0, 1, 32, 2'b10,  0, 32};
      vecs[2] = '{1'b1, 2'b01, 2'b00, 0, 0, 1'b0, 1, 31, 2'b01, 33,  0};
      vecs[3] = '{1'b1, 2'b11, 2'b00, 0, 0, 1'b0, 1, 30, 2'b11, 34, 35};
      vecs[4] = '{1'b0, 2'b00, 2'b10, 0, 3, 1'b0, 1, 28, 2'b00,  0,  0};
      vecs[5] = '{1'b1, 2'b11, 2'b00, 0, 0, 1'b1, 0, 29, 2'b00,  0,  0};
      vecs[6] = '{1'b1, 2'b11, 2'b00, 0, 0, 1'b0, 1, 32, 2'b11, 33, 34};
      vecs[7] = '{1'b1, 2'b00, 2'b00, 0, 0, 1'b0, 1, 30, 2'b00,  0,  0};
      vecs[8] = '{1'b0, 2'b11, 2'b00, 0, 0, 1'b0, 1, 30, 2'b11, 35, 36};

      doReset();
      check("reset_dup_err", int'(dup_err), 0);
      for (int i = 0; i < 9; i++) begin
         drive(vecs[i].av, vecs[i].req, vecs[i].cv, vecs[i].o0, vecs[i].o1, vecs[i].fl);
         #1;
         check($sformatf("v%0d_ready", i), int'(alloc_ready), vecs[i].eRdy);
         check($sformatf("v%0d_free", i), int'(free_count), vecs[i].eFree);
         if (vecs[i].chk[0]) check($sformatf("v%0d_preg0", i), p0(), vecs[i].eP0);
         if (vecs[i].chk[1]) check($sformatf("v%0d_preg1", i), p1(), vecs[i].eP1);
         @(negedge clk);
      end
      check("vec_dup_err", int'(dup_err), 0);

      // Drain the list, then refill it from retire.
      doReset();
      for (int i = 0; i < 16; i++) begin
         drive(1'b1, 2'b11, 2'b00, 0, 0, 1'b0);
         @(negedge clk);
      end
      drive(1'b1, 2'b01, 2'b00, 0, 0, 1'b0);
      #1;
      check("empty_free", int'(free_count), 0);
      check("empty_ready", int'(alloc_ready), 0);
      drive(1'b1, 2'b00, 2'b00, 0, 0, 1'b0);
      #1;
      check("empty_req0_ready", int'(alloc_ready), 1);
      drive(1'b1, 2'b01, 2'b11, 5, 7, 1'b0);
      #1;
      check("release_same_cycle_ready", int'(alloc_ready), 0);
      @(negedge clk);
      drive(1'b0, 2'b11, 2'b00, 0, 0, 1'b0);
      #1;
      check("refill_free", int'(free_count), 2);
      check("refill_preg0", p0(), 5);
      check("refill_preg1", p1(), 7);
      check("refill_ready", int'(alloc_ready), 1);

      // Flush rollback after a partial retire.
      doReset();
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 2'b11, 2'b00, 0, 0, 1'b0);
         @(negedge clk);
      end
      check("rb_free_after_alloc", int'(free_count), 26);
      drive(1'b0, 2'b00, 2'b01, 3, 0, 1'b0);
      @(negedge clk);
      check("rb_free_after_commit", int'(free_count), 27);
      drive(1'b0, 2'b00, 2'b00, 0, 0, 1'b1);
      @(negedge clk);
      drive(1'b0, 2'b11, 2'b00, 0, 0, 1'b0);
      #1;
      check("rb_free_after_flush", int'(free_count), 32);
      check("rb_preg0", p0(), 33);
      check("rb_preg1", p1(), 34);

      // Flush with same-cycle commits.
      doReset();
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, 2'b11, 2'b00, 0, 0, 1'b0);
         @(negedge clk);
      end
      drive(1'b1, 2'b11, 2'b11, 1, 2, 1'b1);
      #1;
      check("fc_ready_in_flush", int'(alloc_ready), 0);
      @(negedge clk);
      drive(1'b0, 2'b11, 2'b00, 0, 0, 1'b0);
      #1;
      check("fc_free", int'(free_count), 32);
      check("fc_preg0", p0(), 34);
      check("fc_preg1", p1(), 35);
      check("fc_dup_err", int'(dup_err), 0);

      // Asynchronous reset in the middle of a cycle.
      drive(1'b1, 2'b11, 2'b00, 0, 0, 1'b0);
      @(negedge clk);
      #2;
      resetn = 1'b0;
      drive(1'b0, 2'b11, 2'b00, 0, 0, 1'b0);
      #1;
      check("async_rst_free", int'(free_count), 32);
      check("async_rst_preg0", p0(), 32);
      @(negedge clk);
      resetn = 1'b1;

      // Release of a preg that is already free.
      doReset();
      drive(1'b0, 2'b00, 2'b01, 40, 0, 1'b0);
      @(negedge clk);
      drive(1'b0, 2'b00, 2'b00, 0, 0, 1'b0);
      #1;
`ifdef FREELIST_DUP_CHECK_EN
      check("dup_set", int'(dup_err), 1);
      repeat (3) @(negedge clk);
      check("dup_sticky", int'(dup_err), 1);
      resetn = 1'b0;
      #1;
      check("dup_cleared_by_reset", int'(dup_err), 0);
`else
      check("dup_tied_low", int'(dup_err), 0);
      resetn = 1'b0;
      #1;
`endif
      @(negedge clk);
      resetn = 1'b1;

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

`default_nettype wire
